// File: rtl/cprv_id_stage_if.sv
// Signal bundle for the ID stage: IF->ID handshake, write-back port, flush and ID->EX bundle.
// The ID stage uses the slave modport; its environment (IF, WB, EX) uses master.
interface cprv_id_stage_if #(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH  = 64
);
  logic                   valid_id_i;
  logic                   ready_id_o;
  logic [INSTR_WIDTH-1:0] instr_id_i;
  logic [DATA_WIDTH-1:0]  pc_id_i;
  logic                   wb_en_i;
  logic [4:0]             wb_rd_i;
  logic [DATA_WIDTH-1:0]  wb_data_i;
  logic                   flush_i;
  logic                   valid_ex_o;
  logic                   ready_ex_i;
  logic [DATA_WIDTH-1:0]  pc_ex_o;
  logic [DATA_WIDTH-1:0]  rs1_data_ex_o;
  logic [DATA_WIDTH-1:0]  rs2_data_ex_o;
  logic [DATA_WIDTH-1:0]  imm_ex_o;
  logic [4:0]             rd_ex_o;
  logic                   we_ex_o;
  logic [3:0]             op_ex_o;
  logic [2:0]             funct3_ex_o;
  logic                   alt_ex_o;
  logic                   word_ex_o;

  modport slave (
    input  valid_id_i, instr_id_i, pc_id_i, wb_en_i, wb_rd_i, wb_data_i, flush_i, ready_ex_i,
    output ready_id_o, valid_ex_o, pc_ex_o, rs1_data_ex_o, rs2_data_ex_o, imm_ex_o, rd_ex_o,
           we_ex_o, op_ex_o, funct3_ex_o, alt_ex_o, word_ex_o
  );

  modport master (
    output valid_id_i, instr_id_i, pc_id_i, wb_en_i, wb_rd_i, wb_data_i, flush_i, ready_ex_i,
    input  ready_id_o, valid_ex_o, pc_ex_o, rs1_data_ex_o, rs2_data_ex_o, imm_ex_o, rd_ex_o,
           we_ex_o, op_ex_o, funct3_ex_o, alt_ex_o, word_ex_o
  );
endinterface

// File: rtl/cprv_id_stage.sv
// RV64I decode stage: field decode, immediate generation, register file read with write-back
// bypass, busy-bit scoreboard for RAW stalls, and a registered bundle toward EX.
module cprv_id_stage #(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH  = 64
) (
  input logic            clk,
  input logic            rst,
  cprv_id_stage_if.slave id_if
);
  localparam logic [3:0] OpLui     = 4'd0;
  localparam logic [3:0] OpAuipc   = 4'd1;
  localparam logic [3:0] OpJal     = 4'd2;
  localparam logic [3:0] OpJalr    = 4'd3;
  localparam logic [3:0] OpBranch  = 4'd4;
  localparam logic [3:0] OpLoad    = 4'd5;
  localparam logic [3:0] OpStore   = 4'd6;
  localparam logic [3:0] OpOpImm   = 4'd7;
  localparam logic [3:0] OpOp      = 4'd8;
  localparam logic [3:0] OpMisc    = 4'd9;
  localparam logic [3:0] OpIllegal = 4'd15;

  logic [INSTR_WIDTH-1:0] instr;
  logic [6:0]             opcode;
  logic [4:0]             rs1, rs2, rd;
  logic [2:0]             funct3;
  logic                   sign;

  assign instr  = id_if.instr_id_i;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign sign   = instr[31];

  logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{(DATA_WIDTH-12){sign}}, instr[31:20]};
  assign imm_s = {{(DATA_WIDTH-12){sign}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(DATA_WIDTH-12){sign}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{(DATA_WIDTH-32){sign}}, instr[31:12], 12'b0};
  assign imm_j = {{(DATA_WIDTH-20){sign}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  logic [3:0]            op_dec;
  logic [DATA_WIDTH-1:0] imm_dec;
  logic                  writes_rd, use_rs1, use_rs2, alt_dec, word_dec, we_dec;

  always_comb begin
    op_dec    = OpIllegal;
    imm_dec   = '0;
    writes_rd = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    alt_dec   = 1'b0;
    word_dec  = 1'b0;
    case (opcode)
      7'h37: begin op_dec = OpLui;    imm_dec = imm_u; writes_rd = 1'b1; end
      7'h17: begin op_dec = OpAuipc;  imm_dec = imm_u; writes_rd = 1'b1; end
      7'h6f: begin op_dec = OpJal;    imm_dec = imm_j; writes_rd = 1'b1; end
      7'h67: begin op_dec = OpJalr;   imm_dec = imm_i; writes_rd = 1'b1; use_rs1 = 1'b1; end
      7'h63: begin op_dec = OpBranch; imm_dec = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'h03: begin op_dec = OpLoad;   imm_dec = imm_i; writes_rd = 1'b1; use_rs1 = 1'b1; end
      7'h23: begin op_dec = OpStore;  imm_dec = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'h13, 7'h1b: begin
        op_dec    = OpOpImm;
        imm_dec   = imm_i;
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
        word_dec  = opcode[3];
        // Only the shift-immediates carry the arithmetic/logical select in bit 30
        alt_dec   = (funct3 == 3'b001 || funct3 == 3'b101) ? instr[30] : 1'b0;
      end
      7'h33, 7'h3b: begin
        op_dec    = OpOp;
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        word_dec  = opcode[3];
        alt_dec   = instr[30];
      end
      7'h0f, 7'h73: op_dec = OpMisc;
      default: op_dec = OpIllegal;
    endcase
  end

  assign we_dec = writes_rd & (rd != 5'd0);

  // Register file: no reset, x0 is never written
  logic [DATA_WIDTH-1:0] rf_q [32];

  always_ff @(posedge clk) begin
    if (id_if.wb_en_i && id_if.wb_rd_i != 5'd0) rf_q[id_if.wb_rd_i] <= id_if.wb_data_i;
  end

  logic [DATA_WIDTH-1:0] rs1_data, rs2_data;
  logic                  wb_hit_rs1, wb_hit_rs2;

  assign wb_hit_rs1 = id_if.wb_en_i && (id_if.wb_rd_i == rs1);
  assign wb_hit_rs2 = id_if.wb_en_i && (id_if.wb_rd_i == rs2);

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1 != 5'd0) rs1_data = wb_hit_rs1 ? id_if.wb_data_i : rf_q[rs1];
    if (rs2 != 5'd0) rs2_data = wb_hit_rs2 ? id_if.wb_data_i : rf_q[rs2];
  end

  // Scoreboard and handshake
  logic [31:0]           busy_q, busy_d;
  logic                  hazard, ready, issue;
  logic                  valid_q, we_q, alt_q, word_q;
  logic [DATA_WIDTH-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]            rd_q;
  logic [3:0]            op_q;
  logic [2:0]            funct3_q;

  assign hazard = (use_rs1 && busy_q[rs1] && !wb_hit_rs1) ||
                  (use_rs2 && busy_q[rs2] && !wb_hit_rs2);
  assign ready  = !rst && !hazard && (!valid_q || id_if.ready_ex_i);
  // A flush also discards whatever is accepted in the same cycle
  assign issue  = id_if.valid_id_i && ready && !id_if.flush_i;

  always_comb begin
    busy_d = busy_q;
    if (id_if.wb_en_i) busy_d[id_if.wb_rd_i] = 1'b0;
    if (id_if.flush_i && valid_q && we_q) busy_d[rd_q] = 1'b0;
    if (issue && we_dec) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      op_q       <= '0;
      funct3_q   <= '0;
      alt_q      <= 1'b0;
      word_q     <= 1'b0;
    end else begin
      valid_q <= issue || (valid_q && !id_if.ready_ex_i && !id_if.flush_i);
      if (issue) begin
        pc_q       <= id_if.pc_id_i;
        rs1_data_q <= rs1_data;
        rs2_data_q <= rs2_data;
        imm_q      <= imm_dec;
        rd_q       <= rd;
        we_q       <= we_dec;
        op_q       <= op_dec;
        funct3_q   <= funct3;
        alt_q      <= alt_dec;
        word_q     <= word_dec;
      end
    end
  end

  assign id_if.ready_id_o    = ready;
  assign id_if.valid_ex_o    = valid_q;
  assign id_if.pc_ex_o       = pc_q;
  assign id_if.rs1_data_ex_o = rs1_data_q;
  assign id_if.rs2_data_ex_o = rs2_data_q;
  assign id_if.imm_ex_o      = imm_q;
  assign id_if.rd_ex_o       = rd_q;
  assign id_if.we_ex_o       = we_q;
  assign id_if.op_ex_o       = op_q;
  assign id_if.funct3_ex_o   = funct3_q;
  assign id_if.alt_ex_o      = alt_q;
  assign id_if.word_ex_o     = word_q;
endmodule

// File: tb/tb_cprv_id_stage.sv
// Bench for cprv_id_stage: directed steps followed by random traffic, all checked against
// a cycle-level reference model of the decode/scoreboard/register-file rules.
module tb_cprv_id_stage;
  localparam int unsigned IW = 32;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cprv_id_stage_if #(.INSTR_WIDTH(IW), .DATA_WIDTH(DW)) bus ();
  cprv_id_stage #(.INSTR_WIDTH(IW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .id_if(bus));

  typedef struct {
    bit          legal;
    logic [3:0]  op;
    bit          has_rd;
    bit          we;
    bit          u1;
    bit          u2;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    bit          alt;
    bit          word;
  } dec_t;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] a;
    logic [63:0] b;
    dec_t        d;
  } bun_t;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] mregs [32];
  bit          mbusy [32];
  bit          ev = 0;
  bun_t        e;
  logic        seen_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sign-extend the low 'bits' bits of v to 64 bits using plain arithmetic
  function automatic logic [63:0] sext(input logic [31:0] v, input int bits);
    logic [63:0] x;
    x = 64'(v) & ((64'd1 << bits) - 64'd1);
    if (x[bits-1]) x = x - (64'd1 << bits);
    return x;
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    d.legal = 1; d.op = 4'd15; d.has_rd = 0; d.u1 = 0; d.u2 = 0; d.imm = '0;
    d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.f3 = ins[14:12];
    d.alt = 0; d.word = 0;
    case (ins[6:0])
      7'h37: begin d.op = 0; d.has_rd = 1; d.imm = sext({ins[31:12], 12'b0}, 32); end
      7'h17: begin d.op = 1; d.has_rd = 1; d.imm = sext({ins[31:12], 12'b0}, 32); end
      7'h6f: begin
        d.op = 2; d.has_rd = 1;
        d.imm = sext({11'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
      end
      7'h67: begin d.op = 3; d.has_rd = 1; d.u1 = 1; d.imm = sext({20'b0, ins[31:20]}, 12); end
      7'h63: begin
        d.op = 4; d.u1 = 1; d.u2 = 1;
        d.imm = sext({19'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
      end
      7'h03: begin d.op = 5; d.has_rd = 1; d.u1 = 1; d.imm = sext({20'b0, ins[31:20]}, 12); end
      7'h23: begin
        d.op = 6; d.u1 = 1; d.u2 = 1; d.imm = sext({20'b0, ins[31:25], ins[11:7]}, 12);
      end
      7'h13, 7'h1b: begin
        d.op = 7; d.has_rd = 1; d.u1 = 1; d.imm = sext({20'b0, ins[31:20]}, 12);
        d.word = (ins[6:0] == 7'h1b);
        d.alt = (d.f3 == 3'd1 || d.f3 == 3'd5) ? ins[30] : 1'b0;
      end
      7'h33, 7'h3b: begin
        d.op = 8; d.has_rd = 1; d.u1 = 1; d.u2 = 1;
        d.word = (ins[6:0] == 7'h3b); d.alt = ins[30];
      end
      7'h0f, 7'h73: d.op = 9;
      default: d.legal = 0;
    endcase
    d.we = d.has_rd && (d.rd != 5'd0);
    return d;
  endfunction

  function automatic logic [63:0] rdreg(input logic [4:0] r);
    if (r == 5'd0) return 64'd0;
    if (bus.wb_en_i && bus.wb_rd_i == r) return bus.wb_data_i;
    return mregs[r];
  endfunction

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic wen, input logic [4:0] wrd, input logic [63:0] wd,
                        input logic fl, input logic rex);
    bus.valid_id_i = v;   bus.instr_id_i = ins; bus.pc_id_i   = pc;
    bus.wb_en_i    = wen; bus.wb_rd_i    = wrd; bus.wb_data_i = wd;
    bus.flush_i    = fl;  bus.ready_ex_i = rex;
  endtask

  // One clock: check ready mid-cycle, advance the model, check the registered bundle
  task automatic tick();
    dec_t        d;
    logic        er, hz, iss, was_rst;
    logic [63:0] a, b;
    @(negedge clk);
    d = ref_decode(bus.instr_id_i);
    was_rst = rst;
    hz = (d.u1 && mbusy[d.rs1] && !(bus.wb_en_i && bus.wb_rd_i == d.rs1)) ||
         (d.u2 && mbusy[d.rs2] && !(bus.wb_en_i && bus.wb_rd_i == d.rs2));
    er = !rst && !hz && (!ev || bus.ready_ex_i);
    chk("ready_id", bus.ready_id_o, er);
    seen_ready = bus.ready_id_o;
    iss = bus.valid_id_i && er && !bus.flush_i;
    a = rdreg(d.rs1);
    b = rdreg(d.rs2);
    if (rst) begin
      ev = 0;
      for (int i = 0; i < 32; i++) mbusy[i] = 0;
    end else begin
      if (bus.wb_en_i) mbusy[bus.wb_rd_i] = 0;
      if (bus.flush_i && ev && e.d.we) mbusy[e.d.rd] = 0;
      if (iss && d.we) mbusy[d.rd] = 1;
      mbusy[0] = 0;
      if (iss) begin
        e.pc = bus.pc_id_i; e.a = a; e.b = b; e.d = d; ev = 1;
      end else if (ev && (bus.flush_i || bus.ready_ex_i)) begin
        ev = 0;
      end
    end
    if (bus.wb_en_i && bus.wb_rd_i != 5'd0) mregs[bus.wb_rd_i] = bus.wb_data_i;
    @(posedge clk);
    #1;
    chk("valid_ex", bus.valid_ex_o, ev);
    if (was_rst) begin
      chk("rst_pc", bus.pc_ex_o, 0);
      chk("rst_imm", bus.imm_ex_o, 0);
      chk("rst_rs1", bus.rs1_data_ex_o, 0);
      chk("rst_rs2", bus.rs2_data_ex_o, 0);
      chk("rst_misc", {bus.rd_ex_o, bus.we_ex_o, bus.op_ex_o, bus.funct3_ex_o, bus.alt_ex_o,
                       bus.word_ex_o}, 0);
    end else if (ev) begin
      chk("pc", bus.pc_ex_o, e.pc);
      chk("op", bus.op_ex_o, e.d.op);
      chk("we", bus.we_ex_o, e.d.we);
      if (e.d.legal) begin
        chk("imm", bus.imm_ex_o, e.d.imm);
        chk("funct3", bus.funct3_ex_o, e.d.f3);
        chk("alt", bus.alt_ex_o, e.d.alt);
        chk("word", bus.word_ex_o, e.d.word);
        if (e.d.has_rd) chk("rd", bus.rd_ex_o, e.d.rd);
        if (e.d.u1) chk("rs1_data", bus.rs1_data_ex_o, e.a);
        if (e.d.u2) chk("rs2_data", bus.rs2_data_ex_o, e.b);
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    case ($urandom_range(0, 15))
      0: ins[6:0] = 7'h37;  1: ins[6:0] = 7'h17;  2: ins[6:0] = 7'h6f;  3: ins[6:0] = 7'h67;
      4: ins[6:0] = 7'h63;  5: ins[6:0] = 7'h03;  6: ins[6:0] = 7'h23;  7: ins[6:0] = 7'h13;
      8: ins[6:0] = 7'h1b;  9: ins[6:0] = 7'h33;  10: ins[6:0] = 7'h3b; 11: ins[6:0] = 7'h0f;
      12: ins[6:0] = 7'h73; 13: ins[6:0] = 7'h00; 14: ins[6:0] = 7'h7f; default: ins[6:0] = 7'h2b;
    endcase
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  localparam logic [31:0] Nop = 32'h0000_0013;

  initial begin
    rst = 1'b1;
    set_in(0, Nop, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    rst = 1'b0;
    for (int r = 1; r < 32; r++) begin
      set_in(0, Nop, 0, 1, 5'(r), {$urandom, $urandom}, 0, 1);
      tick();
    end
    set_in(0, Nop, 0, 1, 5'd5, 64'h1234, 0, 1);
    tick();

    // ADDI x6,x5,-1
    set_in(1, 32'hFFF2_8313, 64'h8000_0000, 0, 0, 0, 0, 1);
    tick();
    chk("addi_rs1", bus.rs1_data_ex_o, 64'h1234);
    chk("addi_imm", bus.imm_ex_o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_rd", bus.rd_ex_o, 6);
    chk("addi_op", bus.op_ex_o, 7);

    // ADD x7,x6,x5 stalls on x6, then issues with the bypassed write-back
    set_in(1, 32'h0053_03B3, 64'h8000_0004, 0, 0, 0, 0, 1);
    tick();
    chk("raw_stall", seen_ready, 0);
    tick();
    set_in(1, 32'h0053_03B3, 64'h8000_0004, 1, 5'd6, 64'h55, 0, 1);
    tick();
    chk("raw_bypass", bus.rs1_data_ex_o, 64'h55);

    // Backpressure: ADD held for 3 cycles, then ADDI x8,x0,5 follows
    set_in(1, 32'h0050_0413, 64'h8000_0008, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_pc", bus.pc_ex_o, 64'h8000_0004);
    end
    bus.ready_ex_i = 1'b1;
    tick();
    chk("bp_release_pc", bus.pc_ex_o, 64'h8000_0008);

    // Immediates
    set_in(1, 32'hFE00_0EE3, 64'h100, 0, 0, 0, 0, 1);
    tick();
    chk("beq_imm", bus.imm_ex_o, 64'hFFFF_FFFF_FFFF_FFFC);
    set_in(1, 32'h0080_00EF, 64'h104, 0, 0, 0, 0, 1);
    tick();
    chk("jal_imm", bus.imm_ex_o, 64'd8);
    set_in(1, 32'h8000_02B7, 64'h108, 0, 0, 0, 0, 1);
    tick();
    chk("lui_imm", bus.imm_ex_o, 64'hFFFF_FFFF_8000_0000);

    // x0: no write enable, write-back ignored even with a same-cycle read
    set_in(1, 32'h0010_0013, 64'h10c, 0, 0, 0, 0, 1);
    tick();
    chk("x0_we", bus.we_ex_o, 0);
    set_in(1, 32'h0000_0533, 64'h110, 1, 5'd0, 64'hFF, 0, 1);
    tick();
    chk("x0_read", bus.rs1_data_ex_o, 0);

    // Flush of a held ADDI x6,x0,1 releases x6
    set_in(1, 32'h0010_0313, 64'h114, 0, 0, 0, 0, 1);
    tick();
    set_in(0, Nop, 0, 0, 0, 0, 0, 0);
    tick();
    bus.flush_i = 1'b1;
    tick();
    chk("flush_valid", bus.valid_ex_o, 0);
    set_in(1, 32'h0003_0593, 64'h118, 0, 0, 0, 0, 1);
    tick();
    chk("flush_busy_clear", seen_ready, 1);

    // Illegal
    set_in(1, 32'h0000_0000, 64'h11c, 0, 0, 0, 0, 1);
    tick();
    chk("illegal_op", bus.op_ex_o, 15);

    // Reset in the middle of a stall
    set_in(1, 32'h0010_0693, 64'h120, 0, 0, 0, 0, 0);
    tick();
    bus.valid_id_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 3) != 0, rand_instr(), {$urandom, $urandom},
             $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), {$urandom, $urandom},
             ev && ($urandom_range(0, 9) == 0), $urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
